// File: rtl/c1541_head_ctl.sv
// Head positioning, track bookkeeping, deferred track save, write-protect blink and track-00 sense.
// Latency: stp change to half_track 2 cycles, track 1 cycle later; save_track combinational from pending/busy.
// Backpressure: busy=1 holds a pending save indefinitely; multiple save events merge into one pulse.
//
// Ports:
//   clk_c1541      drive clock, rising edge
//   reset          synchronous, active-high (does not touch readonly / change timer / change edge detector)
//   stp[1:0]       stepper phase (VIA2 PB[1:0])
//   mtr            spindle motor on; steps only act while set
//   act            drive activity; falling edge is a save event
//   buff_we        track-buffer write strobe; marks the buffered track dirty
//   disk_change    image change level; rising edge latches disk_readonly and starts the WPS blink
//   disk_readonly  image read-only flag
//   busy           SD transfer in progress; holds off save_track
//   half_track     current half-track position
//   track          half_track[6:1], one cycle behind half_track
//   save_track     one-cycle write-back request
//   settled        head has not moved for SETTLE_CYCLES cycles
//   tr00_sense_n   low when track == 0
//   wps_n          write-protect sense, active-low

module c1541_head_ctl #(
    parameter int unsigned HT_RESET      = 36,
    parameter int unsigned HT_MIN        = 1,
    parameter int unsigned HT_MAX        = 80,
    parameter int unsigned SETTLE_CYCLES = 32000,
    parameter int unsigned CHG_CYCLES    = 15000000
) (
    input  logic       clk_c1541,
    input  logic       reset,
    input  logic [1:0] stp,
    input  logic       mtr,
    input  logic       act,
    input  logic       buff_we,
    input  logic       disk_change,
    input  logic       disk_readonly,
    input  logic       busy,
    output logic [6:0] half_track,
    output logic [5:0] track,
    output logic       save_track,
    output logic       settled,
    output logic       tr00_sense_n,
    output logic       wps_n
);

    localparam logic [6:0] HT_RESET_L = 7'(HT_RESET);
    localparam logic [6:0] HT_MIN_L   = 7'(HT_MIN);
    localparam logic [6:0] HT_MAX_L   = 7'(HT_MAX);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = $clog2(CHG_CYCLES + 1);

    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CHG_LOAD    = CW'(CHG_CYCLES);

    // ------------------------------------------------------------------
    // Stage 1: phase compare. stp_r follows stp unconditionally so a step
    // taken with the motor off is simply forgotten, not replayed later.
    // ------------------------------------------------------------------
    logic [1:0] stp_r;
    logic       step_up_q;
    logic       step_dn_q;

    always_ff @(posedge clk_c1541) begin
        stp_r <= stp;
        if (reset) begin
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
        end else begin
            // A phase difference of 2 is ambiguous and ignored.
            step_up_q <= mtr && (stp == stp_r + 2'd1);
            step_dn_q <= mtr && (stp == stp_r - 2'd1);
        end
    end

    logic step_evt;
    logic move_up;
    logic move_dn;

    // A clamped step is still a step event (triggers a save) but does not
    // move the head, so it leaves the settle counter alone.
    assign step_evt = step_up_q | step_dn_q;
    assign move_up  = step_up_q && (half_track < HT_MAX_L);
    assign move_dn  = step_dn_q && (half_track > HT_MIN_L);

    // ------------------------------------------------------------------
    // Stage 2: position register and settle counter.
    // ------------------------------------------------------------------
    logic [SW-1:0] settle_cnt;

    always_ff @(posedge clk_c1541) begin
        if (reset) begin
            half_track <= HT_RESET_L;
            settle_cnt <= '0;
        end else if (move_up) begin
            half_track <= half_track + 7'd1;
            settle_cnt <= SETTLE_LOAD;
        end else if (move_dn) begin
            half_track <= half_track - 7'd1;
            settle_cnt <= SETTLE_LOAD;
        end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SW'(1);
        end
    end

    assign settled = (settle_cnt == '0);

    // Track number is deliberately a plain pipeline copy so that it picks up
    // the reset position one cycle after reset, like any other move.
    always_ff @(posedge clk_c1541) begin
        track <= half_track[6:1];
    end

    assign tr00_sense_n = |track;

    // ------------------------------------------------------------------
    // Dirty tracking and deferred save request.
    // ------------------------------------------------------------------
    logic act_r;
    logic dirty;
    logic pending;
    logic act_fall;
    logic save_evt;
    logic issue;

    assign act_fall = act_r & ~act;
    assign save_evt = step_evt | act_fall;
    // Never let a request escape while a new image is being announced.
    assign issue    = pending & ~busy & ~disk_change & ~reset;

    always_ff @(posedge clk_c1541) begin
        if (reset) begin
            act_r   <= 1'b0;
            dirty   <= 1'b0;
            pending <= 1'b0;
        end else begin
            act_r <= act;
            if (disk_change) begin
                // The buffered track belongs to the old image: drop it.
                dirty   <= 1'b0;
                pending <= 1'b0;
            end else begin
                // A write in the same cycle as the save event is covered by
                // that save, so it is folded into pending, not into dirty.
                if (save_evt && (dirty || buff_we)) begin
                    pending <= 1'b1;
                end else if (issue) begin
                    pending <= 1'b0;
                end

                if (save_evt) begin
                    dirty <= 1'b0;
                end else if (buff_we) begin
                    dirty <= 1'b1;
                end
            end
        end
    end

    assign save_track = issue;

    // ------------------------------------------------------------------
    // Disk change: write-protect blink. Not reset, since a drive reset
    // does not eject the disk; power-up values leave wps_n high.
    // ------------------------------------------------------------------
    logic          disk_change_r = 1'b0;
    logic          readonly      = 1'b0;
    logic [CW-1:0] chg_timer     = '0;
    logic          ch_state      = 1'b0;

    always_ff @(posedge clk_c1541) begin
        disk_change_r <= disk_change;
        if (disk_change && !disk_change_r) begin
            // A new edge during a running blink restarts it.
            readonly  <= disk_readonly;
            chg_timer <= CHG_LOAD;
        end else if (chg_timer != '0) begin
            chg_timer <= chg_timer - CW'(1);
        end
        ch_state <= (chg_timer != '0);
    end

    // The DOS detects a disk swap by seeing the WPS line flip, so the blink
    // inverts whatever the image's real protect state is.
    assign wps_n = ~readonly ^ ch_state;

endmodule

// File: tb/tb_c1541_head_ctl.sv
module tb_c1541_head_ctl;

    localparam int unsigned CHG = 200;

    logic       clk_c1541 = 1'b0;
    logic       reset;
    logic [1:0] stp;
    logic       mtr;
    logic       act;
    logic       buff_we;
    logic       disk_change;
    logic       disk_readonly;
    logic       busy;
    logic [6:0] half_track;
    logic [5:0] track;
    logic       save_track;
    logic       settled;
    logic       tr00_sense_n;
    logic       wps_n;

    int checks   = 0;
    int failures = 0;
    logic [1:0] cur = 2'd0;

    c1541_head_ctl #(
        .HT_RESET     (36),
        .HT_MIN       (1),
        .HT_MAX       (80),
        .SETTLE_CYCLES(32000),
        .CHG_CYCLES   (CHG)
    ) dut (
        .clk_c1541    (clk_c1541),
        .reset        (reset),
        .stp          (stp),
        .mtr          (mtr),
        .act          (act),
        .buff_we      (buff_we),
        .disk_change  (disk_change),
        .disk_readonly(disk_readonly),
        .busy         (busy),
        .half_track   (half_track),
        .track        (track),
        .save_track   (save_track),
        .settled      (settled),
        .tr00_sense_n (tr00_sense_n),
        .wps_n        (wps_n)
    );

    always #5 clk_c1541 = ~clk_c1541;

    task automatic tick();
        @(posedge clk_c1541);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stp = 2'd0; mtr = 1'b0; act = 1'b0; buff_we = 1'b0;
        disk_change = 1'b0; disk_readonly = 1'b0; busy = 1'b0;
        cur = 2'd0;
        #1;
        checks++;
        if (wps_n !== 1'b1) begin failures++; $display("FAIL powerup_wps_n got=%b exp=1", wps_n); end
        tick(); tick(); tick();
        checks++;
        if (half_track !== 7'd36) begin failures++; $display("FAIL reset_half_track got=%0d exp=36", half_track); end
        checks++;
        if (track !== 6'd18) begin failures++; $display("FAIL reset_track got=%0d exp=18", track); end
        checks++;
        if (save_track !== 1'b0) begin failures++; $display("FAIL reset_save_track got=%b exp=0", save_track); end
        checks++;
        if (settled !== 1'b1) begin failures++; $display("FAIL reset_settled got=%b exp=1", settled); end
        checks++;
        if (tr00_sense_n !== 1'b1) begin failures++; $display("FAIL reset_tr00 got=%b exp=1", tr00_sense_n); end
        reset = 1'b0;
        tick();
        checks++;
        if (half_track !== 7'd36) begin failures++; $display("FAIL post_reset_half_track got=%0d exp=36", half_track); end
    endtask

    task automatic test_step_up();
        mtr = 1'b1;
        cur = 2'd1; stp = cur;
        tick();
        checks++;
        if (half_track !== 7'd36) begin failures++; $display("FAIL up_latency got=%0d exp=36", half_track); end
        tick();
        checks++;
        if (half_track !== 7'd37) begin failures++; $display("FAIL up_37 got=%0d exp=37", half_track); end
        checks++;
        if (settled !== 1'b0) begin failures++; $display("FAIL up_settled_low got=%b exp=0", settled); end
        cur = 2'd2; stp = cur;
        tick(); tick();
        checks++;
        if (half_track !== 7'd38) begin failures++; $display("FAIL up_38 got=%0d exp=38", half_track); end
        checks++;
        if (track !== 6'd18) begin failures++; $display("FAIL track_lag got=%0d exp=18", track); end
        cur = 2'd3; stp = cur;
        tick();
        checks++;
        if (track !== 6'd19) begin failures++; $display("FAIL track_19 got=%0d exp=19", track); end
        tick();
        checks++;
        if (half_track !== 7'd39) begin failures++; $display("FAIL up_39 got=%0d exp=39", half_track); end
        // Counter reloaded with 31999 on this edge.
        repeat (31998) tick();
        checks++;
        if (settled !== 1'b0) begin failures++; $display("FAIL settle_still_low got=%b exp=0", settled); end
        tick();
        checks++;
        if (settled !== 1'b1) begin failures++; $display("FAIL settle_done got=%b exp=1", settled); end
    endtask

    task automatic test_clamp_down();
        int bad;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (half_track !== 7'd36) begin failures++; $display("FAIL clamp_start got=%0d exp=36", half_track); end
        for (int i = 0; i < 40; i++) begin
            cur = cur - 2'd1; stp = cur;
            tick(); tick();
            if (i == 33) begin
                checks++;
                if (half_track !== 7'd2) begin failures++; $display("FAIL down_34 got=%0d exp=2", half_track); end
            end
        end
        checks++;
        if (half_track !== 7'd1) begin failures++; $display("FAIL clamp_min got=%0d exp=1", half_track); end
        tick();
        checks++;
        if (track !== 6'd0) begin failures++; $display("FAIL clamp_track got=%0d exp=0", track); end
        checks++;
        if (tr00_sense_n !== 1'b0) begin failures++; $display("FAIL tr00_low got=%b exp=0", tr00_sense_n); end
        repeat (32000) tick();
        checks++;
        if (settled !== 1'b1) begin failures++; $display("FAIL clamp_settled got=%b exp=1", settled); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            cur = cur - 2'd1; stp = cur;
            tick();
            if (settled !== 1'b1 || half_track !== 7'd1) bad++;
            tick();
            if (settled !== 1'b1 || half_track !== 7'd1) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL clamp_extra_steps bad_samples=%0d exp=0", bad); end
    endtask

    task automatic test_no_step();
        mtr = 1'b1;
        cur = cur + 2'd2; stp = cur;
        tick(); tick();
        checks++;
        if (half_track !== 7'd1) begin failures++; $display("FAIL diff2_nostep got=%0d exp=1", half_track); end
        mtr = 1'b0;
        cur = cur + 2'd1; stp = cur;
        tick(); tick();
        checks++;
        if (half_track !== 7'd1) begin failures++; $display("FAIL mtr_off_nostep got=%0d exp=1", half_track); end
        mtr = 1'b1;
        cur = cur + 2'd1; stp = cur;
        tick(); tick();
        checks++;
        if (half_track !== 7'd2) begin failures++; $display("FAIL step_after_lost got=%0d exp=2", half_track); end
    endtask

    task automatic test_save_busy();
        int pulses;
        buff_we = 1'b1; tick(); buff_we = 1'b0;
        busy = 1'b1;
        cur = cur + 2'd1; stp = cur;
        tick(); tick();
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin cur = cur + 2'd1; stp = cur; end
            tick();
            if (save_track === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL busy_hold pulses=%0d exp=0", pulses); end
        checks++;
        if (half_track !== 7'd4) begin failures++; $display("FAIL busy_steps got=%0d exp=4", half_track); end
        busy = 1'b0;
        #1;
        checks++;
        if (save_track !== 1'b1) begin failures++; $display("FAIL busy_release got=%b exp=1", save_track); end
        tick();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (save_track === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL busy_single_pulse extra=%0d exp=0", pulses); end
    endtask

    task automatic test_save_act();
        int pulses;
        // dirty then act falling
        act = 1'b1; tick();
        buff_we = 1'b1; tick(); buff_we = 1'b0;
        act = 1'b0;
        pulses = 0;
        repeat (10) begin tick(); if (save_track === 1'b1) pulses++; end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL act_save pulses=%0d exp=1", pulses); end
        // clean: act falling
        act = 1'b1; tick(); act = 1'b0;
        pulses = 0;
        repeat (10) begin tick(); if (save_track === 1'b1) pulses++; end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL clean_act pulses=%0d exp=0", pulses); end
        // clean: step
        cur = cur + 2'd1; stp = cur;
        pulses = 0;
        repeat (10) begin tick(); if (save_track === 1'b1) pulses++; end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL clean_step pulses=%0d exp=0", pulses); end
        // write in the same cycle as the save event: one pulse, not re-marked
        act = 1'b1; tick();
        act = 1'b0; buff_we = 1'b1; tick(); buff_we = 1'b0;
        pulses = (save_track === 1'b1) ? 1 : 0;
        repeat (9) begin tick(); if (save_track === 1'b1) pulses++; end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL same_cycle_we pulses=%0d exp=1", pulses); end
        act = 1'b1; tick(); act = 1'b0;
        pulses = 0;
        repeat (10) begin tick(); if (save_track === 1'b1) pulses++; end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL we_not_remarked pulses=%0d exp=0", pulses); end
        // disk change drops dirty
        buff_we = 1'b1; tick(); buff_we = 1'b0;
        disk_change = 1'b1; tick(); disk_change = 1'b0;
        act = 1'b1; tick(); act = 1'b0;
        pulses = 0;
        repeat (10) begin tick(); if (save_track === 1'b1) pulses++; end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL change_drops_dirty pulses=%0d exp=0", pulses); end
        // disk change drops pending
        buff_we = 1'b1; tick(); buff_we = 1'b0;
        busy = 1'b1;
        act = 1'b1; tick(); act = 1'b0; tick();
        disk_change = 1'b1; tick(); disk_change = 1'b0;
        busy = 1'b0;
        pulses = 0;
        #1;
        if (save_track === 1'b1) pulses++;
        repeat (10) begin tick(); if (save_track === 1'b1) pulses++; end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL change_drops_pending pulses=%0d exp=0", pulses); end
    endtask

    task automatic test_disk_change();
        int bad;
        repeat (250) tick();
        checks++;
        if (wps_n !== 1'b1) begin failures++; $display("FAIL wps_idle got=%b exp=1", wps_n); end
        disk_readonly = 1'b1; disk_change = 1'b1;
        tick();
        disk_change = 1'b0;
        checks++;
        if (wps_n !== 1'b0) begin failures++; $display("FAIL wps_edge_cycle got=%b exp=0", wps_n); end
        tick();
        checks++;
        if (wps_n !== 1'b1) begin failures++; $display("FAIL wps_blink_start got=%b exp=1", wps_n); end
        bad = 0;
        for (int n = 2; n <= int'(CHG); n++) begin
            if (n == 50) disk_readonly = 1'b0;
            if (n == 100) reset = 1'b1;
            if (n == 104) reset = 1'b0;
            tick();
            if (wps_n !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wps_blink_hold bad_samples=%0d exp=0", bad); end
        checks++;
        if (half_track !== 7'd36) begin failures++; $display("FAIL mid_reset_applied got=%0d exp=36", half_track); end
        tick();
        checks++;
        if (wps_n !== 1'b0) begin failures++; $display("FAIL wps_readonly_after got=%b exp=0", wps_n); end
    endtask

    initial begin
        test_reset();
        test_step_up();
        test_clamp_down();
        test_no_step();
        test_save_busy();
        test_save_act();
        test_disk_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
